// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, transmit FSM state type and CRC-32 byte step.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: framing constants, ARP field constants, CRC constants, tx_state_t, crc32_step8().
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [15:0] ETHTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ETHTYPE_IPV4   = 16'h0800;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;

  localparam int ETH_MIN_FRAME = 60;
  localparam int PREAMBLE_LEN  = 7;
  localparam int ETH_HDR_LEN   = 14;
  localparam int ARP_BODY_LEN  = 28;
  localparam int PAD_LEN       = ETH_MIN_FRAME - ETH_HDR_LEN - ARP_BODY_LEN;
  localparam int FCS_LEN       = 4;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Residue after running the reflected CRC over frame+FCS, shown in
  // bit-reversed (MSB-first) form as quoted for 802.3 receivers.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_ETH_HDR,
    S_ARP_BODY,
    S_PAD,
    S_FCS,
    S_IFG
  } tx_state_t;

  // One byte of the LSB-first (reflected) CRC-32, data consumed bit 0 first.
  function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// 8-bit parallel Ethernet CRC-32 register with synchronous preset and update enable.
// Latency: crc reflects a byte one cycle after it is presented with en=1.
// Backpressure: none; caller gates en.
// Ports: clk, rst_n (sync, active-low), init (preset to CRC_INIT), en, din[7:0], crc[31:0] (raw register, not inverted).
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_step8(crc, din);
    end
  end

endmodule

// File: rtl/arp_reply_tx_gmii.sv
// GMII ARP reply transmitter: one pulse -> preamble/SFD, 60-byte ARP frame (padded), FCS, then IFG.
// Latency: pulse accepted at edge N, first preamble byte driven at edge N+1; tx_done 84 edges after accept.
// Backpressure: none; pulses while busy are dropped, busy stays high until the IFG ends.
// Ports: clk_125m, rst_n (sync, active-low), tx_en_pulse, dst_mac[47:0], dst_ip[31:0],
//        busy, tx_done, gmii_txen, gmii_txd[7:0].
// Optional: define ARP_REQUEST_TX_EN to add input req_mode (1 = broadcast ARP request).
module arp_reply_tx_gmii
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_07_ed_ac_62_00,
  parameter logic [31:0] LOCAL_IP   = 32'hc0_a8_00_02,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        clk_125m,
  input  logic        rst_n,
  input  logic        tx_en_pulse,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
`ifdef ARP_REQUEST_TX_EN
  input  logic        req_mode,
`endif
  output logic        busy,
  output logic        tx_done,
  output logic        gmii_txen,
  output logic [7:0]  gmii_txd
);

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic [6:0]  cnt;
  logic [6:0]  last_idx;
  logic        last;
  logic        accept;

  logic [47:0] lat_mac;
  logic [31:0] lat_ip;
  logic        lat_req;

  logic [47:0] eth_dst;
  logic [47:0] arp_tha;
  logic [15:0] arp_oper;
  logic [13:0][7:0] hdr_pk;
  logic [27:0][7:0] arp_pk;
  logic [3:0][7:0]  fcs_pk;

  logic [7:0]  txd_nxt;
  logic        txen_nxt;
  logic        crc_init;
  logic        crc_en;
  logic [31:0] crc_q;

  assign accept = (state == S_IDLE) && tx_en_pulse;
  assign busy   = (state != S_IDLE);

  // Last byte index of the current state; every state is walked by cnt from 0.
  always_comb begin
    last_idx = 7'd0;
    case (state)
      S_PREAMBLE: last_idx = 7'(PREAMBLE_LEN - 1);
      S_SFD:      last_idx = 7'd0;
      S_ETH_HDR:  last_idx = 7'(ETH_HDR_LEN - 1);
      S_ARP_BODY: last_idx = 7'(ARP_BODY_LEN - 1);
      S_PAD:      last_idx = 7'(PAD_LEN - 1);
      S_FCS:      last_idx = 7'(FCS_LEN - 1);
      S_IFG:      last_idx = 7'(IFG_CYCLES - 1);
      default:    last_idx = 7'd0;
    endcase
  end

  assign last = (cnt == last_idx);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk_125m) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 7'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || state == S_IDLE) ? 7'd0 : cnt + 7'd1;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (tx_en_pulse) state_nxt = S_PREAMBLE;
      S_PREAMBLE: if (last)        state_nxt = S_SFD;
      S_SFD:      if (last)        state_nxt = S_ETH_HDR;
      S_ETH_HDR:  if (last)        state_nxt = S_ARP_BODY;
      S_ARP_BODY: if (last)        state_nxt = S_PAD;
      S_PAD:      if (last)        state_nxt = S_FCS;
      S_FCS:      if (last)        state_nxt = S_IFG;
      S_IFG:      if (last)        state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- request capture
  // Addresses are frozen at accept so the frame in flight never sees input changes.
  always_ff @(posedge clk_125m) begin
    if (!rst_n) begin
      lat_mac <= 48'h0;
      lat_ip  <= 32'h0;
    end else if (accept) begin
      lat_mac <= dst_mac;
      lat_ip  <= dst_ip;
    end
  end

`ifdef ARP_REQUEST_TX_EN
  always_ff @(posedge clk_125m) begin
    if (!rst_n) begin
      lat_req <= 1'b0;
    end else if (accept) begin
      lat_req <= req_mode;
    end
  end
`else
  assign lat_req = 1'b0;
`endif

  // Request frames broadcast and leave THA unknown; replies echo the requester.
  assign eth_dst  = lat_req ? 48'hFFFF_FFFF_FFFF : lat_mac;
  assign arp_tha  = lat_req ? 48'h0 : lat_mac;
  assign arp_oper = lat_req ? ARP_OPER_REQ : ARP_OPER_REPLY;

  // Highest packed element is the first byte on the wire (network order).
  assign hdr_pk = {eth_dst, LOCAL_MAC, ETHTYPE_ARP};
  assign arp_pk = {ARP_HTYPE_ETH, ETHTYPE_IPV4, ARP_HLEN, ARP_PLEN, arp_oper,
                   LOCAL_MAC, LOCAL_IP, arp_tha, lat_ip};
  // FCS goes out low byte first, so element 0 is sent first.
  assign fcs_pk = ~crc_q;

  // ---------------------------------------------------------------- output decode
  always_comb begin
    txd_nxt  = 8'h00;
    txen_nxt = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    case (state)
      S_PREAMBLE: begin
        txd_nxt  = ETH_PREAMBLE;
        txen_nxt = 1'b1;
      end
      S_SFD: begin
        txd_nxt  = ETH_SFD;
        txen_nxt = 1'b1;
        crc_init = 1'b1;
      end
      S_ETH_HDR: begin
        txd_nxt  = hdr_pk[4'(4'd13 - cnt[3:0])];
        txen_nxt = 1'b1;
        crc_en   = 1'b1;
      end
      S_ARP_BODY: begin
        txd_nxt  = arp_pk[5'(5'd27 - cnt[4:0])];
        txen_nxt = 1'b1;
        crc_en   = 1'b1;
      end
      S_PAD: begin
        txd_nxt  = 8'h00;
        txen_nxt = 1'b1;
        crc_en   = 1'b1;
      end
      S_FCS: begin
        txd_nxt  = fcs_pk[cnt[1:0]];
        txen_nxt = 1'b1;
      end
      default: begin
        txd_nxt  = 8'h00;
        txen_nxt = 1'b0;
      end
    endcase
  end

  // CRC consumes exactly the byte being registered onto gmii_txd.
  crc32_d8 u_crc (
    .clk   (clk_125m),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .din   (txd_nxt),
    .crc   (crc_q)
  );

  always_ff @(posedge clk_125m) begin
    if (!rst_n) begin
      gmii_txen <= 1'b0;
      gmii_txd  <= 8'h00;
      tx_done   <= 1'b0;
    end else begin
      gmii_txen <= txen_nxt;
      gmii_txd  <= txd_nxt;
      tx_done   <= (state == S_IFG) && last;
    end
  end

endmodule

// File: tb/tb_arp_reply_tx_gmii.sv
`timescale 1ns/1ps
module tb_arp_reply_tx_gmii;

  localparam logic [47:0] LMAC = 48'h00_07_ed_ac_62_00;
  localparam logic [31:0] LIP  = 32'hc0_a8_00_02;

  logic        clk_125m = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en_pulse = 1'b0;
  logic [47:0] dst_mac = 48'h0;
  logic [31:0] dst_ip = 32'h0;
`ifdef ARP_REQUEST_TX_EN
  logic        req_mode = 1'b0;
`endif
  logic        busy;
  logic        tx_done;
  logic        gmii_txen;
  logic [7:0]  gmii_txd;

  always #4 clk_125m = ~clk_125m;

  arp_reply_tx_gmii dut (
    .clk_125m    (clk_125m),
    .rst_n       (rst_n),
    .tx_en_pulse (tx_en_pulse),
    .dst_mac     (dst_mac),
    .dst_ip      (dst_ip),
`ifdef ARP_REQUEST_TX_EN
    .req_mode    (req_mode),
`endif
    .busy        (busy),
    .tx_done     (tx_done),
    .gmii_txen   (gmii_txen),
    .gmii_txd    (gmii_txd)
  );

  // Rising-edge counter; all stimulus and sampling happen on falling edges.
  int pcnt = 0;
  always @(posedge clk_125m) pcnt <= pcnt + 1;

  // Wire monitor: every transmitted byte, frame start/length and tx_done time.
  byte unsigned all_b[$];
  int fr_start[$];
  int fr_off[$];
  int fr_len[$];
  int done_at[$];
  logic prev_en = 1'b0;
  int cur_start = 0;

  always @(negedge clk_125m) begin
    if (gmii_txen === 1'b1 && prev_en !== 1'b1) begin
      fr_start.push_back(pcnt);
      fr_off.push_back(all_b.size());
      cur_start = pcnt;
    end
    if (gmii_txen === 1'b1) all_b.push_back(gmii_txd);
    if (gmii_txen !== 1'b1 && prev_en === 1'b1) fr_len.push_back(pcnt - cur_start);
    if (tx_done === 1'b1) done_at.push_back(pcnt);
    prev_en = gmii_txen;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reflected CRC-32, one data bit at a time, LSB first.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input byte unsigned b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Expected wire image: 8 preamble/SFD bytes, 60 frame bytes, 4 FCS bytes.
  byte unsigned exp_f[72];

  task automatic build_model(input logic [47:0] mac, input logic [31:0] ip, input logic req);
    logic [479:0] body;
    logic [47:0]  edst;
    logic [47:0]  tha;
    logic [15:0]  oper;
    logic [31:0]  c;
    logic [31:0]  f;
    edst = req ? 48'hFFFF_FFFF_FFFF : mac;
    tha  = req ? 48'h0 : mac;
    oper = req ? 16'h0001 : 16'h0002;
    body = {edst, LMAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, oper,
            LMAC, LIP, tha, ip, 144'h0};
    for (int i = 0; i < 7; i++) exp_f[i] = 8'h55;
    exp_f[7] = 8'hD5;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      exp_f[8+i] = body[479:472];
      c = ref_crc(c, body[479:472]);
      body = body << 8;
    end
    f = ~c;
    for (int k = 0; k < 4; k++) begin
      exp_f[68+k] = f[7:0];
      f = f >> 8;
    end
  endtask

  function automatic logic [63:0] fld(input int fi, input int s, input int n);
    logic [63:0] v;
    v = 64'h0;
    for (int i = 0; i < n; i++) v = {v[55:0], all_b[fr_off[fi]+s+i]};
    return v;
  endfunction

  // Returns 1 when the frame is present and full-length, so field checks are safe.
  task automatic check_frame(input int fi, input int p, input string tag, output bit ok);
    int bad;
    logic [31:0] c;
    ok = 0;
    chk({tag, " frame present"}, 64'(fr_len.size() > fi), 64'd1);
    if (fr_len.size() <= fi) return;
    chk({tag, " start latency"}, 64'(fr_start[fi] - p), 64'd2);
    chk({tag, " txen length"}, 64'(fr_len[fi]), 64'd72);
    if (fr_len[fi] != 72) return;
    bad = -1;
    for (int i = 0; i < 72; i++)
      if (bad < 0 && all_b[fr_off[fi]+i] !== exp_f[i]) bad = i;
    chk({tag, " first bad byte idx"}, 64'(bad), 64'(-1));
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 72; i++) c = ref_crc(c, all_b[fr_off[fi]+i]);
    chk({tag, " crc residue"}, 64'(bitrev32(c)), 64'h00000000C704DD7B);
    ok = 1;
  endtask

  task automatic send(input logic [47:0] mac, input logic [31:0] ip, output int p);
    @(negedge clk_125m);
    dst_mac = mac;
    dst_ip  = ip;
    tx_en_pulse = 1'b1;
    p = pcnt;
    @(negedge clk_125m);
    tx_en_pulse = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int d);
    d = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_125m);
      if (tx_done === 1'b1) begin
        d = pcnt;
        break;
      end
    end
    chk({tag, " tx_done seen"}, 64'(d >= 0), 64'd1);
  endtask

  initial begin
    int p, d, fi, nd, p2, fi2;
    bit ok;
    logic [47:0] rmac;
    logic [31:0] rip;

    // ---- reset state
    repeat (4) @(negedge clk_125m);
    chk("reset gmii_txen", 64'(gmii_txen), 64'd0);
    chk("reset gmii_txd", 64'(gmii_txd), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset tx_done", 64'(tx_done), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_125m);

    // ---- single reply
    fi = fr_start.size();
    send(48'h11_22_33_44_55_66, 32'hc0_a8_00_03, p);
    chk("busy after accept", 64'(busy), 64'd1);
    wait_done("basic", d);
    chk("basic busy at done", 64'(busy), 64'd0);
    chk("basic done latency", 64'(d - p), 64'd85);
    repeat (2) @(negedge clk_125m);
    build_model(48'h11_22_33_44_55_66, 32'hc0_a8_00_03, 1'b0);
    check_frame(fi, p, "basic", ok);
    if (ok) begin
      chk("basic dst mac", fld(fi, 8, 6), 64'h112233445566);
      chk("basic ethertype", fld(fi, 20, 2), 64'h0806);
      chk("basic oper", fld(fi, 28, 2), 64'h0002);
      chk("basic tpa", fld(fi, 46, 4), 64'hc0a80003);
    end

    // ---- ignored second pulse, mid-frame dst_mac change, then back-to-back
    nd = done_at.size();
    fi = fr_start.size();
    send(48'h11_22_33_44_55_66, 32'hc0_a8_00_03, p);
    while (pcnt < p + 3) @(negedge clk_125m);
    dst_mac = 48'hFFFF_FFFF_FFFF;
    dst_ip  = 32'hFFFF_FFFF;
    while (pcnt < p + 5) @(negedge clk_125m);
    tx_en_pulse = 1'b1;
    @(negedge clk_125m);
    tx_en_pulse = 1'b0;
    wait_done("ignore", d);
    rmac = {$urandom(), $urandom()};
    rip  = $urandom();
    dst_mac = rmac;
    dst_ip  = rip;
    tx_en_pulse = 1'b1;
    p2 = d;
    fi2 = fi + 1;
    @(negedge clk_125m);
    tx_en_pulse = 1'b0;
    chk("ignore one tx_done", 64'(done_at.size() - nd), 64'd1);
    chk("ignore one frame", 64'(fr_start.size() - fi), 64'd1);
    build_model(48'h11_22_33_44_55_66, 32'hc0_a8_00_03, 1'b0);
    check_frame(fi, p, "ignore", ok);
    if (ok) chk("midframe tha", fld(fi, 40, 6), 64'h112233445566);
    wait_done("b2b", d);
    repeat (2) @(negedge clk_125m);
    build_model(rmac, rip, 1'b0);
    check_frame(fi2, p2, "b2b", ok);
    if (ok) chk("b2b idle gap", 64'(fr_start[fi2] - (fr_start[fi] + fr_len[fi])), 64'd13);

    // ---- randomized replies
    for (int k = 0; k < 4; k++) begin
      rmac = {$urandom(), $urandom()};
      rip  = $urandom();
      fi = fr_start.size();
      send(rmac, rip, p);
      if (k[0]) begin
        dst_mac = {$urandom(), $urandom()};
        dst_ip  = $urandom();
      end
      wait_done("rand", d);
      repeat (2) @(negedge clk_125m);
      build_model(rmac, rip, 1'b0);
      check_frame(fi, p, $sformatf("rand%0d", k), ok);
    end

    // ---- reset at frame byte 30
    nd = done_at.size();
    fi = fr_start.size();
    send(48'h11_22_33_44_55_66, 32'hc0_a8_00_03, p);
    while (pcnt < p + 32) @(negedge clk_125m);
    chk("abort txen at byte30", 64'(gmii_txen), 64'd1);
    rst_n = 1'b0;
    @(negedge clk_125m);
    chk("abort txen after rst", 64'(gmii_txen), 64'd0);
    chk("abort busy after rst", 64'(busy), 64'd0);
    @(negedge clk_125m);
    rst_n = 1'b1;
    repeat (100) @(negedge clk_125m);
    chk("abort no tx_done", 64'(done_at.size() - nd), 64'd0);
    chk("abort truncated len", 64'((fr_len.size() > fi) ? fr_len[fi] : -1), 64'd31);
    rmac = {$urandom(), $urandom()};
    rip  = $urandom();
    fi = fr_start.size();
    send(rmac, rip, p);
    wait_done("post_abort", d);
    repeat (2) @(negedge clk_125m);
    build_model(rmac, rip, 1'b0);
    check_frame(fi, p, "post_abort", ok);

`ifdef ARP_REQUEST_TX_EN
    // ---- ARP request mode
    rmac = {$urandom(), $urandom()};
    rip  = $urandom();
    req_mode = 1'b1;
    fi = fr_start.size();
    send(rmac, rip, p);
    req_mode = 1'b0;
    wait_done("request", d);
    repeat (2) @(negedge clk_125m);
    build_model(rmac, rip, 1'b1);
    check_frame(fi, p, "request", ok);
    if (ok) begin
      chk("request dst mac", fld(fi, 8, 6), 64'hFFFFFFFFFFFF);
      chk("request oper", fld(fi, 28, 2), 64'h0001);
      chk("request tha", fld(fi, 40, 6), 64'h0);
      chk("request tpa", fld(fi, 46, 4), 64'(rip));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
